// File: rtl/key_encoder8_3_pkg.sv
// Shared types, sizes and helpers for the eight-key encoder and its debouncer.
package key_pkg;

   localparam int KEY_NUM            = 8;
   localparam int CODE_W             = 3;
   localparam int DEB_CYCLES_DEFAULT = 1_000_000;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   // Index of the highest set bit; all-clear encodes as zero.
   function automatic logic [CODE_W-1:0] prio_encode(input logic [KEY_NUM-1:0] pressed);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < KEY_NUM; i++) begin
         if (pressed[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

   // True when two or more bits are set: clearing the lowest set bit leaves something behind.
   function automatic logic multi_pressed(input logic [KEY_NUM-1:0] pressed);
      return (pressed & (pressed - KEY_NUM'(1))) != '0;
   endfunction

endpackage

// File: rtl/key_encoder8_3_if.sv
// Key vector in, encoded key event out.
interface key_encoder8_3_if;
   import key_pkg::*;

   logic [KEY_NUM-1:0] key_n;
   logic [CODE_W-1:0]  code;
   logic               code_valid;
   logic               key_down;
   logic               multi;

   modport master (
      output key_n,
      input  code, code_valid, key_down, multi
   );

   modport slave (
      input  key_n,
      output code, code_valid, key_down, multi
   );
endinterface

// File: rtl/key_encoder8_3_debounce.sv
// Two-flop synchroniser plus shared stability counter for a vector of raw keys.
// The debounced vector only follows the synchronised vector after it has been
// constant for DEB_CYCLES cycles, which also absorbs skew between bits.
module key_debounce #(
   parameter int WIDTH      = 8,
   parameter int DEB_CYCLES = 16,
   parameter int CNT_W      = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] deb_out
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] s_vec_q, s_vec_d;
   logic [WIDTH-1:0] s_prev_q, s_prev_d;
   logic [WIDTH-1:0] deb_vec_q, deb_vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: shift the sync chain, restart on any change, commit once stable.
   always_comb begin
      sync1_d   = raw_in;
      s_vec_d   = sync1_q;
      s_prev_d  = s_vec_q;
      cnt_d     = cnt_q;
      deb_vec_d = deb_vec_q;
      if (s_vec_q != s_prev_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         if (s_vec_q != deb_vec_q) deb_vec_d = s_vec_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers; reset puts every stage at "all keys released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= '1;
         s_vec_q   <= '1;
         s_prev_q  <= '1;
         deb_vec_q <= '1;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= sync1_d;
         s_vec_q   <= s_vec_d;
         s_prev_q  <= s_prev_d;
         deb_vec_q <= deb_vec_d;
         cnt_q     <= cnt_d;
      end
   end

   assign deb_out = deb_vec_q;

endmodule

// File: rtl/key_encoder8_3.sv
// 8-to-3 key encoder: debounced active-low keys, priority encoded, one event
// per press with a full release required between events.
module key_encoder8_3
   import key_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
   parameter int CNT_W      = 24
) (
   input  logic                   clk,
   input  logic                   rst_n,
   key_encoder8_3_if.slave        bus
);

   logic [KEY_NUM-1:0] deb_vec;
   logic [KEY_NUM-1:0] pressed;

   state_t             state_q, state_d;
   logic [CODE_W-1:0]  code_q, code_d;
   logic               code_valid_q, code_valid_d;
   logic               key_down_q, key_down_d;
   logic               multi_q, multi_d;

   key_debounce #(
      .WIDTH      (KEY_NUM),
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_in  (bus.key_n),
      .deb_out (deb_vec)
   );

   assign pressed = ~deb_vec;

   // Event FSM: latch the code on the first debounced press, ignore changes until all released.
   always_comb begin
      state_d      = state_q;
      code_d       = code_q;
      code_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (pressed != '0) begin
               state_d      = HELD;
               code_d       = prio_encode(pressed);
               code_valid_d = 1'b1;
            end
         end
         HELD: begin
            if (pressed == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      key_down_d = (state_d == HELD);
      multi_d    = multi_pressed(pressed);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         code_q       <= '0;
         code_valid_q <= 1'b0;
         key_down_q   <= 1'b0;
         multi_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         key_down_q   <= key_down_d;
         multi_q      <= multi_d;
      end
   end

   assign bus.code       = code_q;
   assign bus.code_valid = code_valid_q;
   assign bus.key_down   = key_down_q;
   assign bus.multi      = multi_q;

endmodule

// File: tb/tb_key_encoder8_3.sv
// Directed bench for key_encoder8_3 with a short debounce window.
module tb_key_encoder8_3;

   localparam int DEB = 16;
   localparam int LAT = DEB + 4;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;
   int   pulse_cnt;
   int   last_pulse;
   int   kd_seen;

   key_encoder8_3_if bus ();

   key_encoder8_3 #(
      .DEB_CYCLES (DEB),
      .CNT_W      (24)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.code_valid === 1'b1) begin
         pulse_cnt++;
         last_pulse = cyc;
      end
      if (bus.key_down === 1'b1) kd_seen = 1;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_mon();
      pulse_cnt  = 0;
      last_pulse = -1000;
      kd_seen    = 0;
   endtask

   task automatic test_reset();
      int t0;
      rst_n     = 1'b0;
      bus.key_n = 8'h00;
      clear_mon();
      wait_cycles(5);
      n_tests++;
      if (bus.code !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", bus.code); end
      n_tests++;
      if (bus.code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.code_valid); end
      n_tests++;
      if (bus.key_down !== 1'b0) begin n_fail++; $display("FAIL reset_key_down got %b want 0", bus.key_down); end
      n_tests++;
      if (bus.multi !== 1'b0) begin n_fail++; $display("FAIL reset_multi got %b want 0", bus.multi); end
      rst_n = 1'b1;
      t0 = cyc;
      wait_cycles(LAT + 10);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL reset_release_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (last_pulse - t0 < LAT - 1 || last_pulse - t0 > LAT + 1) begin
         n_fail++; $display("FAIL reset_release_latency got %0d want %0d+-1", last_pulse - t0, LAT);
      end
      n_tests++;
      if (bus.code !== 3'd7) begin n_fail++; $display("FAIL reset_release_code got %0d want 7", bus.code); end
      n_tests++;
      if (bus.multi !== 1'b1) begin n_fail++; $display("FAIL reset_release_multi got %b want 1", bus.multi); end
      bus.key_n = 8'hFF;
      wait_cycles(LAT + 10);
      n_tests++;
      if (bus.key_down !== 1'b0) begin n_fail++; $display("FAIL reset_release_up got %b want 0", bus.key_down); end
   endtask

   task automatic test_single_press();
      int t0;
      int t1;
      int fall;
      clear_mon();
      bus.key_n = 8'hDF;
      t0 = cyc;
      wait_cycles(40);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL single_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (last_pulse - t0 < LAT - 1 || last_pulse - t0 > LAT + 1) begin
         n_fail++; $display("FAIL single_latency got %0d want %0d+-1", last_pulse - t0, LAT);
      end
      n_tests++;
      if (bus.code !== 3'd5) begin n_fail++; $display("FAIL single_code got %0d want 5", bus.code); end
      n_tests++;
      if (bus.key_down !== 1'b1) begin n_fail++; $display("FAIL single_key_down got %b want 1", bus.key_down); end
      n_tests++;
      if (bus.multi !== 1'b0) begin n_fail++; $display("FAIL single_multi got %b want 0", bus.multi); end
      bus.key_n = 8'hFF;
      t1 = cyc;
      fall = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.key_down === 1'b0) begin
            fall = cyc - t1;
            break;
         end
      end
      n_tests++;
      if (fall < LAT - 1 || fall > LAT + 1) begin
         n_fail++; $display("FAIL single_release_latency got %0d want %0d+-1", fall, LAT);
      end
      wait_cycles(5);
      n_tests++;
      if (bus.code !== 3'd5) begin n_fail++; $display("FAIL single_code_hold got %0d want 5", bus.code); end
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL single_no_release_pulse got %0d want 1", pulse_cnt); end
   endtask

   task automatic test_bounce();
      clear_mon();
      for (int i = 0; i < 12; i++) begin
         bus.key_n[2] = ~bus.key_n[2];
         wait_cycles(5);
      end
      bus.key_n = 8'hFF;
      wait_cycles(40);
      n_tests++;
      if (pulse_cnt !== 0) begin n_fail++; $display("FAIL bounce_pulses got %0d want 0", pulse_cnt); end
      n_tests++;
      if (kd_seen !== 0) begin n_fail++; $display("FAIL bounce_key_down got %0d want 0", kd_seen); end
      for (int i = 0; i < 6; i++) begin
         bus.key_n[2] = ~bus.key_n[2];
         wait_cycles(5);
      end
      bus.key_n = 8'hFB;
      wait_cycles(LAT + 8);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL bounce_settle_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (bus.code !== 3'd2) begin n_fail++; $display("FAIL bounce_settle_code got %0d want 2", bus.code); end
      bus.key_n = 8'hFF;
      wait_cycles(LAT + 10);
   endtask

   task automatic test_priority();
      clear_mon();
      bus.key_n = 8'hF6;
      wait_cycles(LAT + 8);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL prio_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (bus.code !== 3'd3) begin n_fail++; $display("FAIL prio_code got %0d want 3", bus.code); end
      n_tests++;
      if (bus.multi !== 1'b1) begin n_fail++; $display("FAIL prio_multi got %b want 1", bus.multi); end
      bus.key_n = 8'hB6;
      wait_cycles(LAT + 8);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL prio_add_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (bus.code !== 3'd3) begin n_fail++; $display("FAIL prio_add_code got %0d want 3", bus.code); end
      n_tests++;
      if (bus.key_down !== 1'b1) begin n_fail++; $display("FAIL prio_add_key_down got %b want 1", bus.key_down); end
      bus.key_n = 8'hFF;
      wait_cycles(LAT + 10);
   endtask

   task automatic test_repress();
      clear_mon();
      bus.key_n = 8'hFD;
      wait_cycles(LAT + 8);
      n_tests++;
      if (bus.code !== 3'd1) begin n_fail++; $display("FAIL repress_first_code got %0d want 1", bus.code); end
      bus.key_n = 8'hFF;
      wait_cycles(8);
      bus.key_n = 8'hEF;
      wait_cycles(LAT + 10);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL repress_short_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (bus.code !== 3'd1) begin n_fail++; $display("FAIL repress_short_code got %0d want 1", bus.code); end
      bus.key_n = 8'hFF;
      wait_cycles(30);
      n_tests++;
      if (bus.key_down !== 1'b0) begin n_fail++; $display("FAIL repress_release got %b want 0", bus.key_down); end
      bus.key_n = 8'hEF;
      wait_cycles(LAT + 8);
      n_tests++;
      if (pulse_cnt !== 2) begin n_fail++; $display("FAIL repress_pulses got %0d want 2", pulse_cnt); end
      n_tests++;
      if (bus.code !== 3'd4) begin n_fail++; $display("FAIL repress_code got %0d want 4", bus.code); end
      bus.key_n = 8'hFF;
      wait_cycles(LAT + 10);
   endtask

   task automatic test_async_reset();
      int t0;
      clear_mon();
      bus.key_n = 8'h7F;
      wait_cycles(LAT + 8);
      n_tests++;
      if (bus.key_down !== 1'b1 || bus.code !== 3'd7) begin
         n_fail++; $display("FAIL areset_pre got kd=%b code=%0d want kd=1 code=7", bus.key_down, bus.code);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.code !== 3'd0 || bus.key_down !== 1'b0 || bus.multi !== 1'b0 || bus.code_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_clear got code=%0d kd=%b multi=%b vld=%b want all 0",
                  bus.code, bus.key_down, bus.multi, bus.code_valid);
      end
      wait_cycles(1);
      clear_mon();
      rst_n = 1'b1;
      t0 = cyc;
      wait_cycles(LAT + 8);
      n_tests++;
      if (pulse_cnt !== 1) begin n_fail++; $display("FAIL areset_refire_pulses got %0d want 1", pulse_cnt); end
      n_tests++;
      if (last_pulse - t0 < LAT - 1 || last_pulse - t0 > LAT + 1) begin
         n_fail++; $display("FAIL areset_refire_latency got %0d want %0d+-1", last_pulse - t0, LAT);
      end
      n_tests++;
      if (bus.code !== 3'd7) begin n_fail++; $display("FAIL areset_refire_code got %0d want 7", bus.code); end
      bus.key_n = 8'hFF;
      wait_cycles(LAT + 10);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      clear_mon();
      test_reset();
      test_single_press();
      test_bounce();
      test_priority();
      test_repress();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_encoder8_3.md
Name: key_encoder8_3

Overview:
- Inverse of the team's 3-8 decoder: an 8-to-3 encoder for the board's eight active-low key inputs.
- Synchronises and debounces the key vector, then priority-encodes the pressed key into a 3-bit code. The code matches the decoder's input mapping: key i maps to code i.
- Emits a one-cycle valid strobe per press event and holds the code for downstream logic, e.g. feeding the 3-8 decoder to drive LEDs.

Parameters:
- DEB_CYCLES, 1_000_000, stable cycles required before the debounced vector updates (20 ms at 50 MHz); legal range 2..2^24-1.
- CNT_W, 24, debounce counter width; must hold DEB_CYCLES-1.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- key_n  input  8  raw asynchronous keys, 0 = pressed.
- code  output  3  index of the highest pressed key, latched at the press event.
- code_valid  output  1  one-cycle pulse when code is updated.
- key_down  output  1  high while the debounced vector has at least one key pressed.
- multi  output  1  high while more than one debounced key is pressed.

Behaviour:
- Reset (async assert, sync release): both sync stages and the debounced vector become 8'hFF (all released). Counter = 0, state = IDLE, code = 3'b000, code_valid = 0, key_down = 0, multi = 0.
- Synchroniser:
  - Two flops per bit; no cross-bit coherence guarantee.
  - The debouncer absorbs skew between bits.
  - s_vec is the second-stage output.
- Debounce:
  - s_prev registers s_vec.
  - If s_vec != s_prev, the counter clears to 0.
  - Else, if the counter equals DEB_CYCLES-1 and s_vec != deb_vec, deb_vec <= s_vec and the counter holds.
  - Else, the counter increments, saturating at DEB_CYCLES-1.
  - Timing: let T0 be the first cycle s_vec shows a new value that then stays constant. deb_vec updates at T0+DEB_CYCLES.
  - Any glitch shorter than DEB_CYCLES cycles never reaches deb_vec.
- Priority encode (combinational on ~deb_vec): the highest pressed index wins (bit 7 highest). No key pressed encodes as 3'b000, qualified by key_down.
- FSM, two states:
  - IDLE: when deb_vec != 8'hFF, go to HELD. Register code <= encoded value and pulse code_valid for exactly one cycle. Outputs appear one cycle after deb_vec updates.
  - HELD: when deb_vec == 8'hFF, go to IDLE. No code_valid and no code change while in HELD, even if the pressed set changes.
  - A new event therefore requires a full release first (the debounced release, then a debounced press).
- key_down = (state == HELD), registered. multi = population count of ~deb_vec >= 2, registered. Both update the same cycle code_valid first asserts.
- code holds its last value after release until the next press event.
- Simultaneous press of several keys within the debounce window produces one event. code = highest index, multi = 1.
- Reset mid-debounce or mid-HELD returns all state to reset values immediately. Keys still held after reset release produce a fresh event after the sync + DEB_CYCLES + 1 latency.
- Total press latency from a clean key_n edge to code_valid: 2 sync cycles + DEB_CYCLES + 1 register (+1 for the s_prev stage) ≈ DEB_CYCLES+4 cycles. The bench checks a window of ±1 cycle.

Decomposition:
- Shared package key_pkg:
  - state enum (IDLE, HELD)
  - KEY_NUM = 8, CODE_W = 3
  - DEB_CYCLES_DEFAULT
- One natural sub-module, key_debounce: synchroniser + counter + deb_vec, parameterised on width and DEB_CYCLES. It is reusable for the other board key examples.
- Encoder and FSM stay in key_encoder8_3.

Test Plan (DEB_CYCLES = 16 for simulation):
- Reset check: hold rst_n = 0 with key_n = 8'h00 → code = 0, code_valid = 0, key_down = 0, multi = 0. Release reset with keys still pressed → one code_valid with code = 7, multi = 1, about 20 cycles later.
- Single press: key_n = 8'hDF (key 5) held for 40 cycles → exactly one code_valid pulse 19-21 cycles after the edge; code = 3'b101, key_down = 1, multi = 0. Release → key_down falls about 20 cycles later; code stays 5.
- Bounce rejection: toggle key_n[2] every 5 cycles for 60 cycles, then release → no code_valid, key_down stays 0. Then toggle for 30 cycles and settle pressed → one code_valid, code = 2.
- Priority/multi: key_n = 8'hF6 (keys 0 and 3) together → code = 3, multi = 1. Add key 6 while held → no new code_valid, code stays 3.
- Re-press requirement: hold key 1, release for only 8 cycles, press key 4 → no event. Release for 30 cycles, then press key 4 → code_valid with code = 4.
- Async reset mid-HELD: assert rst_n for 1 cycle during HELD, off the clock edge → outputs cleared immediately; code_valid re-fires after the latency window.
